// File: rtl/cla_serial_adder_pkg.sv
// Shared constants and state encoding for the nibble-serial carry-lookahead adder.
package cla_serial_adder_pkg;
  localparam int SLICE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;
endpackage

// File: rtl/cla_serial_adder_cla.sv
// 4-bit carry-lookahead slice; cout[i] is the carry into bit i (cout[0]=cin, cout[4]=carry out).
module cla (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic [4:0] cout
);
  logic [3:0] g, p;

  always_comb begin
    g = a & b;
    p = a ^ b;
    cout[0] = cin;
    cout[1] = g[0] | (p[0] & cin);
    cout[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    cout[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
    cout[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
            | (p[3] & p[2] & p[1] & p[0] & cin);
    sum = p ^ cout[3:0];
  end
endmodule

// File: rtl/cla_serial_adder.sv
// WIDTH-bit adder that walks one 4-bit CLA slice across the operands, LSB nibble first,
// chaining the slice carry through a register. Valid/ready on both sides.
module cla_serial_adder
  import cla_serial_adder_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  localparam int NSLICE = WIDTH / SLICE_W;
  localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NSLICE - 1);

  if ((WIDTH % SLICE_W) != 0 || WIDTH < SLICE_W) begin : g_width_chk
    $fatal(1, "cla_serial_adder: WIDTH must be a multiple of 4 and >= 4");
  end

  state_e                           state_q, state_d;
  logic [NSLICE-1:0][SLICE_W-1:0]   a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic                             carry_q, carry_d;
  logic [IDXW-1:0]                  idx_q, idx_d;
  logic                             cout_q, cout_d, ovf_q, ovf_d;

  logic [SLICE_W-1:0] slc_sum;
  logic [SLICE_W:0]   slc_c;

  cla u_cla (
    .a    (a_q[idx_q]),
    .b    (b_q[idx_q]),
    .cin  (carry_q),
    .sum  (slc_sum),
    .cout (slc_c)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    idx_d   = idx_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          idx_d   = '0;
          state_d = CALC;
        end
      end
      CALC: begin
        sum_d[idx_q] = slc_sum;
        carry_d      = slc_c[SLICE_W];
        if (idx_q == LAST_IDX) begin
          // Top slice: carry into vs. out of the MSB gives signed overflow; idx holds.
          cout_d  = slc_c[SLICE_W];
          ovf_d   = slc_c[SLICE_W-1] ^ slc_c[SLICE_W];
          state_d = DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      idx_q   <= idx_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;
endmodule

// File: doc/cla_serial_adder.md
# cla_serial_adder

Multi-cycle WIDTH-bit adder built around the team's 4-bit carry-lookahead slice. It accepts one operand pair over a valid/ready handshake and feeds the `cla` slice one nibble per cycle, least significant first. It chains the slice carry through a register and assembles the full sum, carry-out and signed overflow. It sits directly upstream and downstream of `cla`, serving as that slice's operand sequencer and result collector for datapaths wider than 4 bits.

## Interface
- WIDTH, 16, operand/sum width; must be a multiple of 4 and ≥ 4.
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low.
- in_valid  in  1  operand pair present.
- in_ready  out  1  block can accept an operand pair.
- a  in  WIDTH  operand A, sampled on accept.
- b  in  WIDTH  operand B, sampled on accept.
- cin  in  1  carry-in, sampled on accept.
- out_valid  out  1  result present.
- out_ready  in  1  consumer takes the result.
- sum  out  WIDTH  a + b + cin, modulo 2^WIDTH.
- cout  out  1  unsigned carry out of bit WIDTH-1.
- ovf  out  1  signed (two's complement) overflow.

## Operation
- NSLICE = WIDTH/4. Internal registers:
  - a_q, b_q (WIDTH)
  - carry_q (1)
  - idx (ceil(log2(NSLICE)), minimum 1 bit)
  - sum_q (WIDTH), cout_q, ovf_q
  - state
- FSM states:
  - IDLE: in_ready=1. When in_valid=1, capture a, b and cin. Set carry_q=cin and idx=0, then go to CALC.
  - CALC: in_ready=0. Drive `cla` with a_q[4·idx+:4], b_q[4·idx+:4] and carry_q. On each edge:
    - sum_q[4·idx+:4] ← slice sum
    - carry_q ← slice cout[4]
    - idx ← idx+1
  - CALC exit: when idx = NSLICE-1, also set cout_q ← slice cout[4] and ovf_q ← slice cout[3] XOR slice cout[4], then go to DONE.
  - DONE: out_valid=1. When out_ready=1, go to IDLE.
- in_ready = (state==IDLE). out_valid = (state==DONE). Both are decoded directly from registered state.
- sum, cout and ovf drive directly from sum_q, cout_q and ovf_q. They are meaningful only while out_valid=1. sum_q may change during CALC.
- Arithmetic:
  - All additions are modulo 2^WIDTH. No saturation.
  - ovf is defined from the carries into and out of the MSB only.
- Boundary conditions:
  - in_valid asserted outside IDLE: ignored; no capture. Upstream must hold it.
  - out_ready asserted outside DONE: ignored.
  - WIDTH=4: CALC lasts exactly one cycle.
  - idx never wraps. It is reset to 0 on every accept.

## Timing
- Reset (rst_n low, asynchronous): state=IDLE, sum_q=0, cout_q=0, ovf_q=0, carry_q=0, idx=0, a_q=b_q=0. Outputs: in_ready=1, out_valid=0, sum=0, cout=0, ovf=0.
- Reset mid-operation (CALC or DONE): the operation is discarded immediately, with no result emitted. The first accept after rst_n rises computes correctly.
- Accept at edge E0. Slices are computed on edges E1..E_NSLICE. out_valid rises after E_NSLICE, giving a latency of NSLICE cycles from accept to out_valid.
- out_valid holds, with sum/cout/ovf stable, until an edge where out_ready=1. out_valid falls after that edge, and in_ready rises in the same cycle.
- Minimum initiation interval is NSLICE+2 cycles, with out_ready held high.
- No combinational path from in_valid to in_ready, or from out_ready to out_valid.

## Structure
- Shared package/header holds:
  - SLICE_W=4
  - state encoding localparams: IDLE=2'd0, CALC=2'd1, DONE=2'd2
- NSLICE and the idx width are localparams derived in-module from WIDTH.
- One sub-module: a single instance of the existing 4-bit `cla`, with its cout[3] and cout[4] both used. No other hierarchy.
- Elaboration check: WIDTH % 4 ≠ 0 or WIDTH < 4 raises a fatal error.

## Test plan
- WIDTH=16, a=16'h1234, b=16'h4321, cin=0 -> sum=16'h5555, cout=0, ovf=0. out_valid exactly 4 cycles after accept.
- a=16'hFFFF, b=16'h0001, cin=0 -> sum=16'h0000, cout=1, ovf=0. Carry ripples through all four slices.
- a=16'h7FFF, b=16'h0001, cin=0 -> sum=16'h8000, cout=0, ovf=1.
- a=16'hFFFF, b=16'hFFFF, cin=1 -> sum=16'hFFFF, cout=1, ovf=0.
- Backpressure:
  - Stimulus: out_ready low for 5 cycles in DONE, with a second op presented on in_valid throughout.
  - Required: result held stable and in_ready=0 during the stall. The second op is accepted only in the cycle after out_ready=1, and its result is correct.
- Reset mid-CALC:
  - Stimulus: rst_n pulsed low while idx=2.
  - Required: out_valid=0, sum=0 and in_ready=1 immediately. A following op a=16'h00FF, b=16'h0001 yields sum=16'h0100.
